pipeline_ctrl_unit: RTL and testbench
=====================================

// Module: pipeline_ctrl_unit
// PURPOSE
//  Producer of the pipeline_ctrl retain/clear controls for the PC register and the i2d, d2a and a2w
//  pipeline registers. Resolves data-cache stalls, load-use hazards, branch mispredicts, halt and
//  interrupt drain. Tracks a halt/interrupt FSM and a stall-length watchdog counter.
//  Sits beside the pipeline registers in the top level; a register with retain=1 ignores clear.
// PARAMETERS
//  STALL_LIMIT  255  consecutive mem-stall cycles before mem_timeout is set
//  CNT_W        8    width of stall_cnt; must satisfy 2**CNT_W > STALL_LIMIT
// PORTS
//  clk          in   1      clock
//  n_rst        in   1      reset, synchronous, active-low
//  d_valid      in   1      D stage (i2d output) holds a valid instr
//  d_load_use   in   1      D instr reads the register a load in A will write
//  a_valid      in   1      A stage (d2a output) holds a valid instr
//  a_mem_access in   1      A instr accesses the d-cache
//  dc_ready     in   1      d-cache completes the A access this cycle
//  a_mispredict in   1      A branch feedback: predicted target/taken != actual
//  a_halt       in   1      A instr is a halt
//  w_valid      in   1      W stage (a2w output) holds a valid instr
//  w_halt       in   1      W instr is a halt
//  irq          in   1      interrupt request, level
//  pc_retain    out  1      hold the PC register
//  i2d_retain   out  1      i2d retain
//  i2d_clear    out  1      i2d clear (bubble)
//  d2a_retain   out  1      d2a retain
//  d2a_clear    out  1      d2a clear
//  a2w_retain   out  1      a2w retain
//  a2w_clear    out  1      a2w clear
//  halted       out  1      core halted (registered)
//  int_ack      out  1      one-cycle pulse: pipeline drained, interrupt may be taken (registered)
//  mem_timeout  out  1      sticky: a stall reached STALL_LIMIT (registered)
//  stall_cnt    out  CNT_W  current consecutive mem-stall cycles, saturating (registered)
// BEHAVIOUR
//  - Controls are combinational from state and inputs. Defaults: all retain=0, clear=0.
//  - While n_rst=0: state=RUN, pc_retain=1, all clears=1, all retains=0.
//    Registered outputs are 0 on the cycle after reset.
//  - Event terms:
//    - mem_stall = a_valid & a_mem_access & ~dc_ready
//    - mp = a_valid & a_mispredict
//    - lu = d_valid & d_load_use & a_valid & a_mem_access
//  - Priority in every non-HALTED state: mem_stall > mp > lu.
//    - mem_stall: pc_retain=1, i2d_retain=1, d2a_retain=1, a2w_clear=1 (bubble into W).
//      No FSM transition. A pending mispredict or halt is re-evaluated when the stall clears.
//    - mp: i2d_clear=1, d2a_clear=1, pc_retain=0 (PC loads the corrected target).
//    - lu: pc_retain=1, i2d_retain=1, d2a_clear=1.
//  - FSM states: RUN, INT_DRAIN, HALT_DRAIN, HALTED.
//  - RUN transitions:
//    - a_valid & a_halt & ~mp & ~mem_stall -> HALT_DRAIN. The halt instr advances to W that edge.
//    - else irq & ~mem_stall -> INT_DRAIN.
//    - Halt wins if both occur together.
//  - INT_DRAIN:
//    - pc_retain=1 and i2d_clear=1 (fetch stopped), except a mispredict cycle forces pc_retain=0.
//    - D, A and W drain normally. Load-use retain still applies; retain overrides clear.
//    - When ~d_valid & ~a_valid & ~w_valid & ~mem_stall: int_ack=1 on the next cycle, -> RUN.
//    - irq dropping mid-drain does not abort the drain.
//  - HALT_DRAIN: pc_retain=1, i2d_clear=1, d2a_clear=1.
//    - w_valid & w_halt -> HALTED; halted=1 from the next cycle.
//  - HALTED: pc_retain=1, all three clears=1.
//    - irq is ignored; only reset exits.
//  - stall_cnt: increments each mem_stall cycle, saturates at 2**CNT_W-1, resets to 0 on the
//    first non-stall cycle.
//  - mem_timeout: set when stall_cnt==STALL_LIMIT-1 while mem_stall (i.e. the
//    STALL_LIMIT-th stall cycle). Cleared only by reset.
// TESTING
//  - Load-use: d_load_use=1 for 1 cycle -> that cycle pc_retain=1, i2d_retain=1, d2a_clear=1;
//    next cycle all controls 0.
//  - Mispredict while mem_stall for 3 cycles -> 3 cycles of pc/i2d/d2a retain plus a2w_clear;
//    then 1 cycle of i2d_clear, d2a_clear, pc_retain=0.
//  - irq in RUN with D, A, W full -> fetch stops; int_ack pulses once after 3 drain cycles;
//    state returns to RUN.
//  - Halt reaches A -> HALT_DRAIN; after w_halt, halted=1 and stays; irq=1 has no effect.
//    Reset clears halted.
//  - STALL_LIMIT=4 stall of 6 cycles -> stall_cnt 1,2,3,4,5,6; mem_timeout rises on the
//    4th stall cycle, stays after the stall ends.
//  - Reset asserted mid-INT_DRAIN -> no int_ack; state RUN; registered outputs 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stage status signals and the control unit.
// The master drives stage status and the slave returns retain/clear controls and status.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             d_valid;
  logic             d_load_use;
  logic             a_valid;
  logic             a_mem_access;
  logic             dc_ready;
  logic             a_mispredict;
  logic             a_halt;
  logic             w_valid;
  logic             w_halt;
  logic             irq;
  logic             pc_retain;
  logic             i2d_retain;
  logic             i2d_clear;
  logic             d2a_retain;
  logic             d2a_clear;
  logic             a2w_retain;
  logic             a2w_clear;
  logic             halted;
  logic             int_ack;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_valid, d_load_use, a_valid, a_mem_access, dc_ready,
           a_mispredict, a_halt, w_valid, w_halt, irq,
    input  pc_retain, i2d_retain, i2d_clear, d2a_retain, d2a_clear,
           a2w_retain, a2w_clear, halted, int_ack, mem_timeout, stall_cnt
  );

  modport slave (
    input  d_valid, d_load_use, a_valid, a_mem_access, dc_ready,
           a_mispredict, a_halt, w_valid, w_halt, irq,
    output pc_retain, i2d_retain, i2d_clear, d2a_retain, d2a_clear,
           a2w_retain, a2w_clear, halted, int_ack, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_unit.sv
// Retain/clear control for the PC, i2d, d2a and a2w registers, with a halt/interrupt
// drain FSM and a saturating watchdog on d-cache stall length.
module pipeline_ctrl_unit #(
  parameter int STALL_LIMIT = 255,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  pipeline_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {RUN, INT_DRAIN, HALT_DRAIN, HALTED} state_t;

  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STALL_LIMIT - 1);

  state_t           state_reg;
  logic             halted_reg;
  logic             int_ack_reg;
  logic             mem_timeout_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic mem_stall, mp, lu, drained;
  logic pc_r, i2d_r, i2d_c, d2a_r, d2a_c, a2w_c;

  assign mem_stall = bus.a_valid & bus.a_mem_access & ~bus.dc_ready;
  assign mp        = bus.a_valid & bus.a_mispredict;
  assign lu        = bus.d_valid & bus.d_load_use & bus.a_valid & bus.a_mem_access;
  assign drained   = ~bus.d_valid & ~bus.a_valid & ~bus.w_valid & ~mem_stall;

  always_comb begin
    pc_r  = 1'b0;
    i2d_r = 1'b0;
    i2d_c = 1'b0;
    d2a_r = 1'b0;
    d2a_c = 1'b0;
    a2w_c = 1'b0;
    if (!n_rst || state_reg == HALTED) begin
      pc_r  = 1'b1;
      i2d_c = 1'b1;
      d2a_c = 1'b1;
      a2w_c = 1'b1;
    end else begin
      if (state_reg == INT_DRAIN) begin
        pc_r  = 1'b1;
        i2d_c = 1'b1;
      end
      if (state_reg == HALT_DRAIN) begin
        pc_r  = 1'b1;
        i2d_c = 1'b1;
        d2a_c = 1'b1;
      end
      if (mem_stall) begin
        pc_r  = 1'b1;
        i2d_r = 1'b1;
        d2a_r = 1'b1;
        a2w_c = 1'b1;
      end else if (mp) begin
        // PC must load the corrected target even while fetch is otherwise stopped
        pc_r  = 1'b0;
        i2d_c = 1'b1;
        d2a_c = 1'b1;
      end else if (lu) begin
        pc_r  = 1'b1;
        i2d_r = 1'b1;
        d2a_c = 1'b1;
      end
      i2d_c = i2d_c & ~i2d_r;
      d2a_c = d2a_c & ~d2a_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg       <= RUN;
      halted_reg      <= 1'b0;
      int_ack_reg     <= 1'b0;
      mem_timeout_reg <= 1'b0;
      stall_cnt_reg   <= '0;
    end else begin
      int_ack_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (bus.a_valid & bus.a_halt & ~mp & ~mem_stall)
            state_reg <= HALT_DRAIN;
          else if (bus.irq & ~mem_stall)
            state_reg <= INT_DRAIN;
        end
        INT_DRAIN: begin
          if (drained) begin
            state_reg   <= RUN;
            int_ack_reg <= 1'b1;
          end
        end
        HALT_DRAIN: begin
          if (bus.w_valid & bus.w_halt) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end
        end
        HALTED:  state_reg <= HALTED;
        default: state_reg <= RUN;
      endcase

      if (mem_stall) begin
        if (stall_cnt_reg != '1)
          stall_cnt_reg <= stall_cnt_reg + 1'b1;
        if (stall_cnt_reg == LIMIT_CNT)
          mem_timeout_reg <= 1'b1;
      end else begin
        stall_cnt_reg <= '0;
      end
    end
  end

  assign bus.pc_retain   = pc_r;
  assign bus.i2d_retain  = i2d_r;
  assign bus.i2d_clear   = i2d_c;
  assign bus.d2a_retain  = d2a_r;
  assign bus.d2a_clear   = d2a_c;
  assign bus.a2w_retain  = 1'b0;
  assign bus.a2w_clear   = a2w_c;
  assign bus.halted      = halted_reg;
  assign bus.int_ack     = int_ack_reg;
  assign bus.mem_timeout = mem_timeout_reg;
  assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit with STALL_LIMIT=4; controls are packed as
// {pc_r, i2d_r, i2d_c, d2a_r, d2a_c, a2w_r, a2w_c} for comparison.
module tb_pipeline_ctrl_unit;

  localparam int CNT_W = 8;

  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_RST   = 7'b101_0101;
  localparam logic [6:0] C_STALL = 7'b110_1001;
  localparam logic [6:0] C_MP    = 7'b001_0100;
  localparam logic [6:0] C_LU    = 7'b110_0100;
  localparam logic [6:0] C_INT   = 7'b101_0000;
  localparam logic [6:0] C_HALTD = 7'b101_0100;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl_unit #(.STALL_LIMIT(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {bus.pc_retain, bus.i2d_retain, bus.i2d_clear, bus.d2a_retain,
            bus.d2a_clear, bus.a2w_retain, bus.a2w_clear};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.d_valid      = 1'b0;
    bus.d_load_use   = 1'b0;
    bus.a_valid      = 1'b0;
    bus.a_mem_access = 1'b0;
    bus.dc_ready     = 1'b1;
    bus.a_mispredict = 1'b0;
    bus.a_halt       = 1'b0;
    bus.w_valid      = 1'b0;
    bus.w_halt       = 1'b0;
    bus.irq          = 1'b0;
  endtask

  initial begin
    // reset
    n_rst = 1'b0;
    idle();
    #1;
    check("reset_ctl", 32'(ctl()), 32'(C_RST));
    step();
    step();
    n_rst = 1'b1;
    #1;
    check("post_rst_halted", 32'(bus.halted), 0);
    check("post_rst_int_ack", 32'(bus.int_ack), 0);
    check("post_rst_timeout", 32'(bus.mem_timeout), 0);
    check("post_rst_stall_cnt", 32'(bus.stall_cnt), 0);
    check("idle_ctl", 32'(ctl()), 32'(C_NONE));
    $display("step: reset done");

    // load-use for one cycle
    bus.d_valid = 1'b1; bus.d_load_use = 1'b1; bus.a_valid = 1'b1; bus.a_mem_access = 1'b1;
    #1;
    check("lu_ctl", 32'(ctl()), 32'(C_LU));
    step();
    bus.d_load_use = 1'b0; bus.a_mem_access = 1'b0;
    #1;
    check("lu_after_ctl", 32'(ctl()), 32'(C_NONE));
    $display("step: load-use done");

    // mispredict held behind a 3-cycle d-cache stall
    bus.a_mem_access = 1'b1; bus.dc_ready = 1'b0; bus.a_mispredict = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check("mp_stall_ctl", 32'(ctl()), 32'(C_STALL));
      step();
      check("mp_stall_cnt", 32'(bus.stall_cnt), 32'(i));
    end
    bus.dc_ready = 1'b1;
    #1;
    check("mp_ctl", 32'(ctl()), 32'(C_MP));
    step();
    check("mp_cnt_cleared", 32'(bus.stall_cnt), 0);
    check("mp_no_timeout", 32'(bus.mem_timeout), 0);
    $display("step: mispredict behind stall done");

    // interrupt drain with D, A, W full; load-use during drain
    idle();
    bus.d_valid = 1'b1; bus.a_valid = 1'b1; bus.w_valid = 1'b1; bus.irq = 1'b1;
    #1;
    check("irq_run_ctl", 32'(ctl()), 32'(C_NONE));
    step();
    bus.irq = 1'b0;
    bus.d_load_use = 1'b1; bus.a_mem_access = 1'b1;
    #1;
    check("drain_lu_ctl", 32'(ctl()), 32'(C_LU));
    step();
    check("drain1_ack", 32'(bus.int_ack), 0);
    bus.d_load_use = 1'b0; bus.a_mem_access = 1'b0; bus.d_valid = 1'b0;
    #1;
    check("drain2_ctl", 32'(ctl()), 32'(C_INT));
    step();
    check("drain2_ack", 32'(bus.int_ack), 0);
    bus.a_valid = 1'b0;
    #1;
    check("drain3_ctl", 32'(ctl()), 32'(C_INT));
    step();
    check("drain3_ack", 32'(bus.int_ack), 0);
    bus.w_valid = 1'b0;
    step();
    check("int_ack_pulse", 32'(bus.int_ack), 1);
    check("back_to_run_ctl", 32'(ctl()), 32'(C_NONE));
    step();
    check("int_ack_once", 32'(bus.int_ack), 0);
    $display("step: interrupt drain done");

    // halt
    bus.a_valid = 1'b1; bus.a_halt = 1'b1;
    #1;
    check("halt_run_ctl", 32'(ctl()), 32'(C_NONE));
    step();
    bus.a_valid = 1'b0; bus.a_halt = 1'b0; bus.w_valid = 1'b1; bus.w_halt = 1'b1;
    #1;
    check("halt_drain_ctl", 32'(ctl()), 32'(C_HALTD));
    check("halt_drain_halted", 32'(bus.halted), 0);
    step();
    idle();
    bus.irq = 1'b1;
    bus.a_valid = 1'b1; bus.a_mem_access = 1'b1; bus.dc_ready = 1'b0;
    #1;
    check("halted_flag", 32'(bus.halted), 1);
    check("halted_ctl", 32'(ctl()), 32'(C_RST));
    step();
    step();
    check("halted_stays", 32'(bus.halted), 1);
    check("halted_no_ack", 32'(bus.int_ack), 0);
    check("halted_ctl2", 32'(ctl()), 32'(C_RST));
    n_rst = 1'b0;
    idle();
    step();
    n_rst = 1'b1;
    #1;
    check("halt_rst_halted", 32'(bus.halted), 0);
    check("halt_rst_ctl", 32'(ctl()), 32'(C_NONE));
    $display("step: halt done");

    // 6-cycle stall against STALL_LIMIT=4
    bus.a_valid = 1'b1; bus.a_mem_access = 1'b1; bus.dc_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("wd_stall_cnt", 32'(bus.stall_cnt), 32'(i));
      check("wd_timeout", 32'(bus.mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
    end
    bus.dc_ready = 1'b1;
    step();
    check("wd_cnt_cleared", 32'(bus.stall_cnt), 0);
    check("wd_timeout_sticky", 32'(bus.mem_timeout), 1);
    $display("step: watchdog done");

    // reset in the middle of an interrupt drain
    idle();
    bus.w_valid = 1'b1; bus.irq = 1'b1;
    step();
    #1;
    check("mid_drain_ctl", 32'(ctl()), 32'(C_INT));
    n_rst = 1'b0;
    bus.w_valid = 1'b0;
    #1;
    check("mid_drain_rst_ctl", 32'(ctl()), 32'(C_RST));
    step();
    n_rst = 1'b1;
    bus.irq = 1'b0;
    #1;
    check("mid_drain_no_ack", 32'(bus.int_ack), 0);
    check("mid_drain_timeout", 32'(bus.mem_timeout), 0);
    check("mid_drain_run_ctl", 32'(ctl()), 32'(C_NONE));
    step();
    check("mid_drain_no_ack2", 32'(bus.int_ack), 0);
    $display("step: reset mid-drain done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
